// File: rtl/shl8_iter_if.sv
// shl8_iter_if: request/result bundle for the iterative 8-bit left shifter
interface shl8_iter_if;
  logic       start;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] d_out;
  logic       carry;
  logic       ovf;
  modport master (output start, d_in, shamt, input busy, done, d_out, carry, ovf);
  modport slave (input start, d_in, shamt, output busy, done, d_out, carry, ovf);
endinterface

// File: rtl/shl8_iter.sv
// shl8_iter: iterative shift-left engine, one bit per clock, with carry-out and sticky sign-change overflow
module shl8_iter (
  input logic        clk,
  input logic        reset,
  shl8_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t     state, state_nx;
  logic [2:0] cnt;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE)  ? (bus.start ? SHIFT : IDLE) :
               (state == SHIFT) ? ((cnt == 3'd0) ? DONE : SHIFT) : IDLE;
  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
  end
  // Results are only touched on an accepted start or a live shift step, so they hold through DONE/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.d_out <= 8'h00;
      cnt       <= 3'd0;
      bus.carry <= 1'b0;
      bus.ovf   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      bus.d_out <= bus.d_in;
      cnt       <= bus.shamt;
      bus.carry <= 1'b0;
      bus.ovf   <= 1'b0;
    end else if (state == SHIFT && cnt != 3'd0) begin
      bus.d_out <= {bus.d_out[6:0], 1'b0};
      bus.carry <= bus.d_out[7];
      bus.ovf   <= bus.ovf | (bus.d_out[7] ^ bus.d_out[6]);
      cnt       <= cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_shl8_iter.sv
// tb_shl8_iter: scoreboard-driven bench for shl8_iter covering latency, flags, ignored starts, reset and back-to-back
module tb_shl8_iter;
  typedef struct packed {logic [7:0] d; logic c; logic o;} res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  shl8_iter_if bus ();
  shl8_iter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  res_t sb[$];
  res_t last;
  int tests = 0;
  int fails = 0;

  function automatic res_t model(input logic [7:0] d, input logic [2:0] s);
    res_t r;
    r = '{d: d, c: 1'b0, o: 1'b0};
    for (int i = 0; i < int'(s); i++) begin
      r.o = r.o | (r.d[7] ^ r.d[6]);
      r.c = r.d[7];
      r.d = r.d << 1;
    end
    return r;
  endfunction

  task automatic start_op(input logic [7:0] d, input logic [2:0] s, input res_t exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_in  = d;
    bus.shamt = s;
    sb.push_back(exp);
  endtask

  // mode 0: drop start after acceptance, 1: toggle start with d_in=0, 2: hold start
  task automatic wait_done(input logic [2:0] s, input int mode, input string nm);
    int  n = 0;
    bit  seen = 0;
    res_t got;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mode == 0) bus.start = 1'b0;
      if (mode == 1) begin bus.start = ~bus.start; bus.d_in = 8'h00; end
      if (bus.done) seen = 1;
      else if (bus.busy) n++;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: done never seen within 20 cycles", nm);
      return;
    end
    tests++;
    if (n !== int'(s) + 1) begin
      fails++;
      $display("FAIL %s latency: busy cycles %0d, required %0d", nm, n, int'(s) + 1);
    end
    if (mode == 1) bus.start = 1'b1;
    got = '{d: bus.d_out, c: bus.carry, o: bus.ovf};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: done with empty queue", nm);
    end else begin
      last = sb.pop_front();
      if (got !== last) begin
        fails++;
        $display("FAIL %s result: d_out=%h carry=%b ovf=%b, required d_out=%h carry=%b ovf=%b",
                 nm, got.d, got.c, got.o, last.d, last.c, last.o);
      end
    end
  endtask

  task automatic check_hold(input string nm);
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++;
      $display("FAIL %s pulse: busy=%b done=%b after done, required 0 0", nm, bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.d_out, bus.carry, bus.ovf} !== last) begin
      fails++;
      $display("FAIL %s hold: d_out=%h carry=%b ovf=%b, required %h %b %b",
               nm, bus.d_out, bus.carry, bus.ovf, last.d, last.c, last.o);
    end
  endtask

  task automatic check_zero(input string nm);
    tests++;
    if ({bus.busy, bus.done, bus.d_out, bus.carry, bus.ovf} !== 12'h000) begin
      fails++;
      $display("FAIL %s: busy=%b done=%b d_out=%h carry=%b ovf=%b, required all 0",
               nm, bus.busy, bus.done, bus.d_out, bus.carry, bus.ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.d_in = 8'hA5;
    bus.shamt = 3'd2;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_vectors();
    start_op(8'h81, 3'd3, '{d: 8'h08, c: 1'b0, o: 1'b1});
    wait_done(3'd3, 0, "v81_3");
    check_hold("v81_3");
    start_op(8'hFF, 3'd7, '{d: 8'h80, c: 1'b1, o: 1'b0});
    wait_done(3'd7, 0, "vFF_7");
    check_hold("vFF_7");
    start_op(8'h40, 3'd1, '{d: 8'h80, c: 1'b0, o: 1'b1});
    wait_done(3'd1, 0, "v40_1");
    check_hold("v40_1");
    start_op(8'h5A, 3'd0, '{d: 8'h5A, c: 1'b0, o: 1'b0});
    wait_done(3'd0, 0, "v5A_0");
    check_hold("v5A_0");
  endtask

  task automatic test_ignore_start();
    start_op(8'hC3, 3'd5, '{d: 8'h60, c: 1'b0, o: 1'b1});
    wait_done(3'd5, 1, "ignore_C3_5");
    check_hold("ignore_C3_5");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_in = 8'hAA;
    bus.shamt = 3'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check_zero("reset_mid");
    @(negedge clk);
    check_zero("reset_priority");
    reset = 1'b0;
    bus.start = 1'b0;
    start_op(8'h01, 3'd2, '{d: 8'h04, c: 1'b0, o: 1'b0});
    wait_done(3'd2, 0, "after_reset_01_2");
    check_hold("after_reset_01_2");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[3];
    logic [2:0] s[3];
    int extra = 0;
    d[0] = 8'h37; s[0] = 3'd4;
    d[1] = 8'($urandom); s[1] = 3'($urandom_range(0, 7));
    d[2] = 8'($urandom); s[2] = 3'($urandom_range(0, 7));
    start_op(d[0], s[0], model(d[0], s[0]));
    for (int k = 0; k < 3; k++) begin
      wait_done(s[k], 2, $sformatf("b2b_%0d", k));
      if (k < 2) begin
        bus.d_in = d[k+1];
        bus.shamt = s[k+1];
        sb.push_back(model(d[k+1], s[k+1]));
      end else bus.start = 1'b0;
      @(negedge clk);
      tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        fails++;
        $display("FAIL b2b_idle_%0d: busy=%b done=%b, required 0 0", k, bus.busy, bus.done);
      end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    tests++;
    if (extra !== 0 || sb.size() !== 0) begin
      fails++;
      $display("FAIL b2b_extra: %0d extra done pulses, %0d queued, required 0 0", extra, sb.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.d_in = 8'h00;
    bus.shamt = 3'd0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
